// File: rtl/fb_arb_pkg.sv
// Shared definitions for the frame-buffer port arbiter.
// Contents: FSM state encoding, default parameter values and a
// compile-time clog2 used to size the beat and wait counters.
package fb_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int unsigned AW_DEF            = 16;
  localparam int unsigned DW_DEF            = 24;
  localparam int unsigned BURST_DEF         = 16;
  localparam int unsigned MEM_LAT_DEF       = 2;
  localparam int unsigned HOST_MAX_WAIT_DEF = 64;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fb_arb_rd_pipe.sv
// Read-valid delay line: tracks issued reads through the memory latency.
// Ports:
//   clock_pixel, reset_n : clock, asynchronous active-low clear
//   rd_issue             : a read is on the memory bus this cycle
//   rd_valid             : read data for an issue DEPTH cycles ago is valid
module fb_arb_rd_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clock_pixel,
  input  logic reset_n,
  input  logic rd_issue,
  output logic rd_valid
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clock_pixel or negedge reset_n) begin
        if (!reset_n) sr_q <= '0;
        else          sr_q <= rd_issue;
      end
    end else begin : g_many
      always_ff @(posedge clock_pixel or negedge reset_n) begin
        if (!reset_n) sr_q <= '0;
        else          sr_q <= {sr_q[DEPTH-2:0], rd_issue};
      end
    end
  endgenerate

  assign rd_valid = sr_q[DEPTH-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: scanout read bursts (priority) versus
// single-word host writes, all in the clock_pixel domain.
// Ports:
//   clock_pixel, reset_n          : clock, asynchronous active-low reset
//   sc_req/sc_addr/sc_grant       : scanout burst request, base, grant pulse
//   sc_rdata/sc_rvalid            : scanout read data (mem_rdata) and valid
//   hw_req/hw_addr/hw_wdata/hw_ack: host write request and accept pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port
//   busy                          : a burst is in progress
// Optional: define FB_ARB_STARVE_EN to let a host that has waited
// HOST_MAX_WAIT cycles win one decision over scanout.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned AW            = AW_DEF,
  parameter int unsigned DW            = DW_DEF,
  parameter int unsigned BURST         = BURST_DEF,
  parameter int unsigned MEM_LAT       = MEM_LAT_DEF,
  parameter int unsigned HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic          clock_pixel,
  input  logic          reset_n,
  input  logic          sc_req,
  input  logic [AW-1:0] sc_addr,
  output logic          sc_grant,
  output logic [DW-1:0] sc_rdata,
  output logic          sc_rvalid,
  input  logic          hw_req,
  input  logic [AW-1:0] hw_addr,
  input  logic [DW-1:0] hw_wdata,
  output logic          hw_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned    BW        = clog2(BURST);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] base_q, base_d;
  logic          mem_en_d, mem_we_d, sc_grant_d, hw_ack_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;
  logic          decide, host_ok, host_force;

`ifdef FB_ARB_STARVE_EN
  localparam int unsigned WW = clog2(HOST_MAX_WAIT + 1);
  logic [WW-1:0] wait_q;

  // Saturating count of cycles the host has been kept waiting.
  always_ff @(posedge clock_pixel or negedge reset_n) begin
    if (!reset_n)                       wait_q <= '0;
    else if (hw_ack)                    wait_q <= '0;
    else if (hw_req && (wait_q != '1))  wait_q <= wait_q + WW'(1);
  end

  assign host_force = hw_req && !hw_ack && (32'(wait_q) >= HOST_MAX_WAIT);
`else
  assign host_force = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clock_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sc_grant  <= 1'b0;
      hw_ack    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      sc_grant  <= sc_grant_d;
      hw_ack    <= hw_ack_d;
    end
  end

  // Decision in IDLE and at the last beat; otherwise step the burst.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    sc_grant_d  = 1'b0;
    hw_ack_d    = 1'b0;
    decide      = (state_q == ST_IDLE) || (beat_q == LAST_BEAT);
    // hw_ack high means the host's previous word is on the bus right now.
    host_ok     = hw_req && !hw_ack;

    if (decide) begin
      beat_d = '0;
      if (sc_req && !host_force) begin
        state_d    = ST_BURST;
        base_d     = sc_addr;
        mem_en_d   = 1'b1;
        mem_addr_d = sc_addr;
        sc_grant_d = 1'b1;
      end else if (host_ok) begin
        state_d     = ST_IDLE;
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = hw_addr;
        mem_wdata_d = hw_wdata;
        hw_ack_d    = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      beat_d     = beat_q + BW'(1);
      mem_en_d   = 1'b1;
      // Natural AW-bit wrap of the burst address.
      mem_addr_d = base_q + AW'(beat_q) + AW'(1);
    end
  end

  fb_arb_rd_pipe #(.DEPTH(MEM_LAT)) u_rd_pipe (
    .clock_pixel (clock_pixel),
    .reset_n     (reset_n),
    .rd_issue    (mem_en & ~mem_we),
    .rd_valid    (sc_rvalid)
  );

  assign sc_rdata = mem_rdata;
  assign busy     = (state_q == ST_BURST);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter (BURST=4, MEM_LAT=2, HOST_MAX_WAIT=8).
module tb_fb_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 24;

  logic          clock_pixel, reset_n;
  logic          sc_req, sc_grant, sc_rvalid;
  logic [AW-1:0] sc_addr;
  logic [DW-1:0] sc_rdata;
  logic          hw_req, hw_ack;
  logic [AW-1:0] hw_addr;
  logic [DW-1:0] hw_wdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, mp0;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_cnt, grant_cnt;

  fb_port_arbiter #(
    .AW(AW), .DW(DW), .BURST(4), .MEM_LAT(2), .HOST_MAX_WAIT(8)
  ) dut (
    .clock_pixel (clock_pixel),
    .reset_n     (reset_n),
    .sc_req      (sc_req),
    .sc_addr     (sc_addr),
    .sc_grant    (sc_grant),
    .sc_rdata    (sc_rdata),
    .sc_rvalid   (sc_rvalid),
    .hw_req      (hw_req),
    .hw_addr     (hw_addr),
    .hw_wdata    (hw_wdata),
    .hw_ack      (hw_ack),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  initial clock_pixel = 1'b0;
  always #5 clock_pixel = ~clock_pixel;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, 8'hC3};
  endfunction

  // Two-cycle read latency memory model.
  always @(posedge clock_pixel) begin
    mp0       <= (mem_en && !mem_we) ? mdata(mem_addr) : '0;
    mem_rdata <= mp0;
  end

  task automatic step();
    @(posedge clock_pixel);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " mem_en"},    32'(mem_en),    32'h0);
    chk({tag, " mem_we"},    32'(mem_we),    32'h0);
    chk({tag, " mem_addr"},  32'(mem_addr),  32'h0);
    chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, " sc_grant"},  32'(sc_grant),  32'h0);
    chk({tag, " hw_ack"},    32'(hw_ack),    32'h0);
    chk({tag, " sc_rvalid"}, 32'(sc_rvalid), 32'h0);
    chk({tag, " busy"},      32'(busy),      32'h0);
  endtask

  initial begin
    reset_n  = 1'b0;
    sc_req   = 1'b0;
    sc_addr  = '0;
    hw_req   = 1'b0;
    hw_addr  = '0;
    hw_wdata = '0;
    step();
    step();
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    step();

    // 1. single burst at 0x0100
    sc_req  = 1'b1;
    sc_addr = 16'h0100;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) sc_req = 1'b0;
      chk($sformatf("t1 grant c%0d", c), 32'(sc_grant), 32'(c == 1));
      chk($sformatf("t1 en c%0d", c),    32'(mem_en),   32'(c <= 4));
      chk($sformatf("t1 busy c%0d", c),  32'(busy),     32'(c <= 4));
      if (c <= 4) begin
        chk($sformatf("t1 we c%0d", c),   32'(mem_we),   32'h0);
        chk($sformatf("t1 addr c%0d", c), 32'(mem_addr), 32'h0100 + 32'(c - 1));
      end
      chk($sformatf("t1 rvalid c%0d", c), 32'(sc_rvalid), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6)
        chk($sformatf("t1 rdata c%0d", c), 32'(sc_rdata), 32'(mdata(16'h0100 + 16'(c - 3))));
    end

    // 2. held host request: write, gap, write
    hw_req   = 1'b1;
    hw_addr  = 16'h0020;
    hw_wdata = 24'hABCDEF;
    step();
    chk("t2 ack c1",   32'(hw_ack),    32'h1);
    chk("t2 en c1",    32'(mem_en),    32'h1);
    chk("t2 we c1",    32'(mem_we),    32'h1);
    chk("t2 addr c1",  32'(mem_addr),  32'h0020);
    chk("t2 wdata c1", 32'(mem_wdata), 32'hABCDEF);
    step();
    chk("t2 ack c2", 32'(hw_ack), 32'h0);
    chk("t2 en c2",  32'(mem_en), 32'h0);
    step();
    chk("t2 ack c3", 32'(hw_ack), 32'h1);
    chk("t2 we c3",  32'(mem_we), 32'h1);
    hw_req = 1'b0;
    step();
    chk("t2 ack c4", 32'(hw_ack), 32'h0);
    chk("t2 en c4",  32'(mem_en), 32'h0);

    // 3. simultaneous requests: burst first, then the write
    sc_req  = 1'b1;
    sc_addr = 16'h0200;
    hw_req  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) sc_req = 1'b0;
      chk($sformatf("t3 grant c%0d", c), 32'(sc_grant), 32'(c == 1));
      chk($sformatf("t3 ack c%0d", c),   32'(hw_ack),   32'(c == 5));
      chk($sformatf("t3 we c%0d", c),    32'(mem_we),   32'(c == 5));
      chk($sformatf("t3 addr c%0d", c),  32'(mem_addr),
          (c == 5) ? 32'h0020 : 32'h0200 + 32'(c - 1));
    end
    hw_req = 1'b0;
    step();
    chk("t3 rvalid drain", 32'(sc_rvalid), 32'h1);
    step();
    step();

    // 4. address wrap
    sc_req  = 1'b1;
    sc_addr = 16'hFFFE;
    for (int c = 1; c <= 4; c++) begin
      logic [AW-1:0] ea;
      step();
      if (c == 1) sc_req = 1'b0;
      ea = 16'hFFFE + 16'(c - 1);
      chk($sformatf("t4 addr c%0d", c), 32'(mem_addr), 32'(ea));
    end
    step();
    step();
    step();

    // 5. starvation guard
    sc_req   = 1'b1;
    sc_addr  = 16'h0300;
    hw_req   = 1'b1;
    hw_addr  = 16'h0030;
    hw_wdata = 24'h123456;
`ifdef FB_ARB_STARVE_EN
    for (int c = 1; c <= 10; c++) begin
      step();
      chk($sformatf("t5 grant c%0d", c), 32'(sc_grant), 32'(c == 1 || c == 5 || c == 10));
      chk($sformatf("t5 ack c%0d", c),   32'(hw_ack),   32'(c == 9));
      if (c == 9) begin
        chk("t5 we c9",   32'(mem_we),   32'h1);
        chk("t5 addr c9", 32'(mem_addr), 32'h0030);
      end
      if (c == 10) chk("t5 addr c10", 32'(mem_addr), 32'h0300);
    end
`else
    ack_cnt   = 0;
    grant_cnt = 0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (hw_ack)   ack_cnt++;
      if (sc_grant) grant_cnt++;
    end
    chk("t5 no hw_ack", 32'(ack_cnt),   32'd0);
    chk("t5 grants",    32'(grant_cnt), 32'd50);
`endif
    sc_req = 1'b0;
    hw_req = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("t5 settled busy", 32'(busy), 32'h0);

    // 6. reset mid-burst
    sc_req  = 1'b1;
    sc_addr = 16'h0400;
    step();
    sc_req = 1'b0;
    step();
    step();
    chk("t6 beat2 addr", 32'(mem_addr), 32'h0402);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("t6 async");
    step();
    step();
    chk("t6 rvalid in reset", 32'(sc_rvalid), 32'h0);
    reset_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("t6 rvalid post c%0d", c), 32'(sc_rvalid), 32'h0);
    end
    sc_req  = 1'b1;
    sc_addr = 16'h0500;
    step();
    sc_req = 1'b0;
    chk("t6 restart grant", 32'(sc_grant), 32'h1);
    chk("t6 restart addr",  32'(mem_addr), 32'h0500);
    step();
    step();
    chk("t6 restart rvalid", 32'(sc_rvalid), 32'h1);
    chk("t6 restart rdata",  32'(sc_rdata),  32'(mdata(16'h0500)));
    for (int c = 0; c < 5; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbitrates a single-port frame-buffer memory between the display scanout reader and a host pixel writer, in the `clock_pixel` domain ahead of the TMDS encoders. Scanout reads are issued as atomic fixed-length bursts with priority, so the active area never starves. Host writes are single-word and fill the remaining slots. An optional guard bounds host wait time.

## Interface
- `AW`, 16: memory address width.
- `DW`, 24: data width, packed {R,G,B}.
- `BURST`, 16: reads per scanout grant; legal range is 2 or more.
- `MEM_LAT`, 2: memory read latency in cycles, from `mem_en` with `~mem_we` to `mem_rdata` valid; legal range is 1 or more.
- `HOST_MAX_WAIT`, 64: starvation threshold. Used only when `FB_ARB_STARVE_EN` is defined.

- `clock_pixel` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sc_req` in 1: scanout burst request. Held until `sc_grant`.
- `sc_addr` in AW: burst base address. Sampled when the request is accepted.
- `sc_grant` out 1: one-cycle pulse in the cycle beat 0 is issued.
- `sc_rdata` out DW: equals `mem_rdata`.
- `sc_rvalid` out 1: `sc_rdata` is valid this cycle.
- `hw_req` in 1: host write request.
- `hw_addr` in AW: host write address.
- `hw_wdata` in DW: host write data.
- `hw_ack` out 1: one-cycle pulse in the cycle the write is on the memory bus.
- `mem_en`, `mem_we` out 1: memory strobes.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- There are two states, IDLE and BURST. All `mem_*`, `sc_grant` and `hw_ack` outputs are registered.
- **IDLE edge decision:**
  - If `sc_req`: latch `sc_addr`, go to BURST with beat=0, `mem_en`=1, `mem_we`=0, `sc_grant`=1.
  - Else if `hw_req` and `hw_ack` is low: issue the write (`mem_en`=1, `mem_we`=1, `hw_ack`=1) and stay in IDLE.
  - Else: `mem_en`=0.
- **BURST beat k:** `mem_addr` = base+k, modulo 2^AW (wraps 0xFFFF→0x0000). While k<BURST-1, the next beat is k+1.
- **At beat BURST-1**, the same decision as IDLE is made, so a back-to-back burst or a host write follows with no bubble. Only the write case and the idle case return to IDLE.
- Host throughput is at most one word every 2 cycles. A host request is never accepted in the cycle after its `hw_ack`.
- **Read valid pipeline:** an MEM_LAT-deep shift register fed by `mem_en & ~mem_we`, whose output drives `sc_rvalid`. Writes may issue while earlier reads are still draining.
- `sc_req` is sampled only in IDLE and at the last beat. The requester drops or re-presents it after `sc_grant`.

## Timing
- **Reset values:** every output is 0, the state is IDLE, beat=0, the valid pipeline is cleared, and the wait counter is 0.
- **Burst timeline:** `sc_req` sampled at edge 0:
  - `sc_grant` and `mem_addr`=base appear in cycle 1.
  - Addresses base..base+BURST-1 appear in cycles 1..BURST.
  - `sc_rvalid` is high in cycles 1+MEM_LAT..BURST+MEM_LAT.
- **Host write:** `hw_req` sampled at edge 0 gives write and `hw_ack` in cycle 1.
- **Simultaneous `sc_req` and `hw_req`:** scanout wins, unless the guard fires (see Configuration).
- **Reset asserted mid-burst:** outputs clear immediately. In-flight reads are dropped and no `sc_rvalid` is produced afterwards. A new burst starts from the base address after reset is released.

## Configuration
- **With `FB_ARB_STARVE_EN` defined:**
  - A wait counter increments each cycle `hw_req` is high without `hw_ack`, saturates, and clears on `hw_ack`.
  - At any decision point where the count is at least HOST_MAX_WAIT, the host write wins over `sc_req`.
  - The pending `sc_req` is then served at the next decision.
- **Without it:** strict scanout priority. The host can starve indefinitely and the counter logic is absent.

## Structure
- Package `fb_arb_pkg`:
  - State encodings IDLE=1'b0, BURST=1'b1.
  - Default parameter constants.
  - A clog2 function for the beat counter width.
- One sub-module, `fb_arb_rd_pipe`: the MEM_LAT-deep valid delay line, with asynchronous active-low clear.

## Test plan
1. **Single burst.** BURST=4, MEM_LAT=2, `sc_addr`=0x0100 → `sc_grant` in cycle 1; `mem_addr` 0x0100..0x0103 in cycles 1–4; `sc_rvalid` in cycles 3–6 carrying the memory model data.
2. **Held host request.** IDLE, `hw_addr`=0x0020, `hw_wdata`=0xABCDEF, `hw_req` held → write plus `hw_ack` in cycle 1; no access in cycle 2; next write in cycle 3.
3. **Simultaneous requests.** `sc_req` and `hw_req` both at edge 0 → burst in cycles 1–4; host write and `hw_ack` in cycle 5.
4. **Address wrap.** `sc_addr`=0xFFFE, BURST=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
5. **Starvation guard.** `sc_req` held continuously, `hw_req` held, HOST_MAX_WAIT=8:
   - Macro defined: `hw_ack` at the first burst end where wait ≥ 8, followed by the next burst.
   - Macro undefined: no `hw_ack` within 200 cycles.
6. **Reset mid-burst.** `reset_n` low at beat 2 → all outputs 0 asynchronously; `sc_rvalid` stays 0 after release; a new request restarts from its base address.
